// File: rtl/mux41_scan_ctrl.sv
// mux41_scan_ctrl: drives a 4:1 majority-logic mux with a latched 4-bit word,
// steps the select through all four channels, samples y0 after LAT cycles of
// pipeline delay, reassembles the word and flags any mismatch.
module mux41_scan_ctrl #(
    parameter int unsigned LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       x4,
    output logic       x5,
    input  logic       y0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_err,
    output logic       busy
);

    // Counter must reach LAT+3 without wrapping.
    localparam int unsigned CW = $clog2(LAT + 5);
    localparam int          LAT_I      = int'(LAT);
    localparam logic [CW-1:0] CAP_FIRST  = CW'(LAT);
    localparam logic [CW-1:0] CAP_LAST   = CW'(LAT + 3);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     word_q, word_d;
    logic [3:0]     dat_q, dat_d;
    logic [1:0]     sel_q, sel_d;
    logic [3:0]     out_data_q, out_data_d;
    logic           cap_en;
    logic [1:0]     cap_idx;

    // Next-state, counter, mux drive and capture logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        out_data_d = out_data_q;
        cap_en     = (int'(cnt_q) >= LAT_I);
        cap_idx    = 2'(cnt_q - CAP_FIRST);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    dat_d   = in_data;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE, DRAIN: begin
                // y0 is only looked at inside the capture window, so X elsewhere is harmless.
                if (cap_en) begin
                    out_data_d[cap_idx] = y0;
                end
                if (cnt_q == CAP_LAST) begin
                    dat_d   = 4'd0;
                    sel_d   = 2'd0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q < DRIVE_LAST) begin
                        sel_d = sel_q + 2'd1;
                    end else begin
                        // Select parks at 3 with data unchanged while late samples arrive.
                        state_d = DRAIN;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= 4'd0;
            dat_q      <= 4'd0;
            sel_q      <= 2'd0;
            out_data_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            out_data_q <= out_data_d;
        end
    end

    assign x0        = dat_q[0];
    assign x1        = dat_q[1];
    assign x2        = dat_q[2];
    assign x3        = dat_q[3];
    assign x4        = sel_q[0];
    assign x5        = sel_q[1];
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_err   = out_valid && (out_data_q != word_q);

endmodule
